branch_resolve_queue: RTL

Tracks every in-flight conditional-branch prediction from fetch until the branch resolves in execute, then produces the predictor training pulse and, on a mispredict, the pipeline flush, redirect PC and global-history restore value. It is the resolution side of the gshare predictor: it consumes the prediction stream and drives the predictor's update port (`update`, `updatePc`, `reality`). Resolutions arrive strictly in program order; the block is a circular FIFO with registered outputs.

---
 rtl/branch_resolve_queue_if.sv | 38 +++
 rtl/branch_resolve_queue.sv | 79 +++++++
 2 files changed

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: prediction push, resolve and predictor-update bundle
interface branch_resolve_queue_if #(
  parameter int bit_width = 32,
  parameter int hist_bits = 12,
  parameter int depth = 8
);
  logic predValid;
  logic [bit_width-1:0] predPc;
  logic predTaken;
  logic [bit_width-1:0] predTarget;
  logic [hist_bits-1:0] predHistory;
  logic resolveValid;
  logic resolveTaken;
  logic [bit_width-1:0] resolveTarget;
  logic full;
  logic empty;
  logic [$clog2(depth):0] count;
  logic update;
  logic [bit_width-1:0] updatePc;
  logic reality;
  logic flush;
  logic [bit_width-1:0] redirectPc;
  logic [hist_bits-1:0] restoreHistory;
  logic overflow;
  logic underflow;
  modport master (
    output predValid, predPc, predTaken, predTarget, predHistory,
    output resolveValid, resolveTaken, resolveTarget,
    input full, empty, count, update, updatePc, reality,
    input flush, redirectPc, restoreHistory, overflow, underflow
  );
  modport slave (
    input predValid, predPc, predTaken, predTarget, predHistory,
    input resolveValid, resolveTaken, resolveTarget,
    output full, empty, count, update, updatePc, reality,
    output flush, redirectPc, restoreHistory, overflow, underflow
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order branch resolution FIFO; BRQ_TARGET_CHECK_EN adds target mispredict detection
module branch_resolve_queue #(
  parameter int bit_width = 32,
  parameter int depth = 8,
  parameter int hist_bits = 12
) (
  input logic clk,
  input logic rst_n,
  branch_resolve_queue_if.slave bus
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] cap = (aw+1)'(depth);
  logic [bit_width-1:0] pc_q [depth];
  logic [hist_bits-1:0] hs_q [depth];
  logic [depth-1:0] tk_q;
  logic [aw-1:0] head, tail;
  logic [aw:0] cnt;
  logic do_res, do_push, mis, tmis;
`ifdef BRQ_TARGET_CHECK_EN
  logic [bit_width-1:0] tg_q [depth];
  assign tmis = tk_q[head] && bus.resolveTaken && tg_q[head] != bus.resolveTarget;
  // predicted targets are only kept when target checking is built in
  always_ff @(posedge clk)
    if (do_push) tg_q[tail] <= bus.predTarget;
`else
  assign tmis = 1'b0;
`endif
  assign bus.count = cnt;
  assign bus.full = cnt == cap;
  assign bus.empty = cnt == '0;
  // a resolve against an empty queue is ignored; a full queue only accepts a push alongside a resolve
  always_comb begin
    do_res = bus.resolveValid && cnt != '0;
    mis = tk_q[head] != bus.resolveTaken || tmis;
    do_push = bus.predValid && (cnt != cap || do_res);
  end
  // entry storage needs no reset: occupancy is tracked by the pointers
  always_ff @(posedge clk)
    if (do_push) begin
      pc_q[tail] <= bus.predPc;
      tk_q[tail] <= bus.predTaken;
      hs_q[tail] <= bus.predHistory;
    end
  // pointers, occupancy, registered training/flush outputs and sticky error flags
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt <= '0;
      bus.update <= 1'b0;
      bus.updatePc <= '0;
      bus.reality <= 1'b0;
      bus.flush <= 1'b0;
      bus.redirectPc <= '0;
      bus.restoreHistory <= '0;
      bus.overflow <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.update <= do_res;
      bus.flush <= do_res && mis;
      bus.overflow <= bus.overflow | (bus.predValid && cnt == cap && !bus.resolveValid);
      bus.underflow <= bus.underflow | (bus.resolveValid && cnt == '0);
      if (do_res) begin
        bus.updatePc <= pc_q[head];
        bus.reality <= bus.resolveTaken;
      end
      if (do_res && mis) begin
        bus.redirectPc <= bus.resolveTaken ? bus.resolveTarget : pc_q[head] + bit_width'(4);
        bus.restoreHistory <= {hs_q[head][hist_bits-2:0], bus.resolveTaken};
        head <= '0;
        tail <= '0;
        cnt <= '0;
      end else begin
        head <= head + aw'(do_res);
        tail <= tail + aw'(do_push);
        cnt <= cnt + (aw+1)'(do_push) - (aw+1)'(do_res);
      end
    end
endmodule
